// File: rtl/french_move_driver.sv
// rtl/french_move_driver.sv - frame-divided movement tick generator with LFSR direction code
// Counts VGA frames in RUN and emits a one-cycle timer_done with a fresh random direction.
module french_move_driver #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned DIV_L0    = 8,
  parameter int unsigned DIV_L1    = 6,
  parameter int unsigned DIV_L2    = 4,
  parameter int unsigned DIV_L3    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        freeze,
  input  logic [1:0]  speed_level,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        timer_done,
  output logic [3:0]  random,
  output logic [7:0]  tick_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FREEZE = 2'd2} state_t;

  state_t      st;
  logic [7:0]  frame_cnt;
  logic [7:0]  div_active;
  logic [7:0]  div_sel;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        frame_ok;
  logic        tick;

  always_comb begin
    div_sel = 8'(DIV_L0);
    case (speed_level)
      2'd0: div_sel = 8'(DIV_L0);
      2'd1: div_sel = 8'(DIV_L1);
      2'd2: div_sel = 8'(DIV_L2);
      2'd3: div_sel = 8'(DIV_L3);
      default: div_sel = 8'(DIV_L0);
    endcase
  end

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // A frame right behind a tick is dropped so timer_done can never stay high two cycles.
  assign frame_ok = (st == RUN) && enable && !freeze && startOfFrame && !timer_done;
  assign tick     = frame_ok && (frame_cnt == div_active - 8'd1);
  assign state    = st;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st         <= IDLE;
      frame_cnt  <= 8'd0;
      div_active <= 8'(DIV_L0);
      lfsr       <= LFSR_SEED;
      random     <= 4'd0;
      tick_count <= 8'd0;
      timer_done <= 1'b0;
    end else begin
      timer_done <= 1'b0;
      if (!enable) begin
        st        <= IDLE;
        frame_cnt <= 8'd0;
      end else begin
        case (st)
          IDLE: begin
            st         <= RUN;
            div_active <= div_sel;
          end
          RUN: begin
            if (freeze) begin
              st <= FREEZE;
            end else if (tick) begin
              frame_cnt  <= 8'd0;
              timer_done <= 1'b1;
              tick_count <= tick_count + 8'd1;
              div_active <= div_sel;
              if (!seed_load)
                random <= lfsr_next[3:0];
            end else if (frame_ok) begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          FREEZE: begin
            if (!freeze)
              st <= RUN;
          end
          default: st <= IDLE;
        endcase
      end

      // A seed load overrides the step of a coincident tick.
      if (seed_load)
        lfsr <= (seed == 16'd0) ? LFSR_SEED : seed;
      else if (tick)
        lfsr <= lfsr_next;
    end
  end

endmodule

// File: tb/tb_french_move_driver.sv
// tb/tb_french_move_driver.sv - scoreboard bench for french_move_driver
module tb_french_move_driver;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic        freeze = 1'b0;
  logic [1:0]  speed_level = 2'd0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        timer_done;
  logic [3:0]  random;
  logic [7:0]  tick_count;
  logic [1:0]  state;

  french_move_driver dut (
    .CLK(CLK), .RESET(RESET), .startOfFrame(startOfFrame), .enable(enable),
    .freeze(freeze), .speed_level(speed_level), .seed_load(seed_load), .seed(seed),
    .timer_done(timer_done), .random(random), .tick_count(tick_count), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] r;
    logic [7:0] tc;
    int         cy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_td = 1'b0;

  logic [15:0] m_lfsr = 16'hACE1;
  logic [3:0]  m_random = 4'd0;
  logic [7:0]  m_tcount = 8'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every observed tick is matched against the oldest expected one.
  always @(negedge CLK) begin
    if (RESET) begin
      prev_td <= 1'b0;
    end else begin
      prev_td <= timer_done;
      if (timer_done) begin
        total++;
        if (prev_td) begin
          bad++;
          $display("FAIL back_to_back_tick at cycle %0d", cyc);
        end else if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_tick at cycle %0d tick_count %0d", cyc, tick_count);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (random !== e.r || tick_count !== e.tc || cyc != e.cy) begin
            bad++;
            $display("FAIL tick_content: got random=%0h tick_count=%0d cycle=%0d expected random=%0h tick_count=%0d cycle=%0d",
                     random, tick_count, cyc, e.r, e.tc, e.cy);
          end
        end
      end
    end
  end

  task automatic frame(input bit exp_tick, input bit do_seed = 1'b0, input logic [15:0] sv = 16'd0);
    logic [15:0] nxt;
    exp_t e;
    @(negedge CLK);
    startOfFrame = 1'b1;
    seed_load = do_seed;
    seed = sv;
    nxt = step(m_lfsr);
    if (exp_tick) begin
      if (!do_seed) m_random = nxt[3:0];
      m_tcount = m_tcount + 8'd1;
      e.r = m_random; e.tc = m_tcount; e.cy = cyc + 1;
      q.push_back(e);
    end
    if (do_seed) m_lfsr = (sv == 16'd0) ? 16'hACE1 : sv;
    else if (exp_tick) m_lfsr = nxt;
    @(negedge CLK);
    startOfFrame = 1'b0;
    seed_load = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL missing_tick: got %0d pending expected 0 pending", q.size());
      q.delete();
    end
  endtask

  task automatic frames_no_tick(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  task automatic load_seed(input logic [15:0] sv);
    @(negedge CLK);
    seed_load = 1'b1;
    seed = sv;
    @(negedge CLK);
    seed_load = 1'b0;
    m_lfsr = (sv == 16'd0) ? 16'hACE1 : sv;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_timer_done", {15'd0, timer_done}, 16'd0);
    chk("reset_random", {12'd0, random}, 16'd0);
    chk("reset_tick_count", {8'd0, tick_count}, 16'd0);
    chk("reset_state", {14'd0, state}, 16'd0);
    RESET = 1'b0;

    // First tick after 8 frames: lfsr ACE1 -> 59C3, random 3.
    enable = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("state_run", {14'd0, state}, 16'd1);
    frames_no_tick(7);
    speed_level = 2'd3;
    frame(1'b1);
    chk("first_lfsr_model", m_lfsr, 16'h59C3);
    chk("first_random", {12'd0, random}, 16'h3);

    // Speed 3: tick every 2 frames; change to speed 0 mid-interval.
    for (int i = 0; i < 5; i++) begin
      frame(1'b0);
      frame(1'b1);
    end
    chk("five_ticks_count", {8'd0, tick_count}, 16'd6);
    frame(1'b0);
    speed_level = 2'd0;
    frame(1'b1);
    frames_no_tick(7);
    frame(1'b1);

    // Freeze after 3 of 8 frames.
    frames_no_tick(3);
    freeze = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("state_freeze", {14'd0, state}, 16'd2);
    frames_no_tick(20);
    freeze = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("state_resume", {14'd0, state}, 16'd1);
    frames_no_tick(4);
    frame(1'b1);

    // Zero seed loads ACE1; seed load on a tick frame keeps random.
    load_seed(16'd0);
    frames_no_tick(7);
    frame(1'b1);
    chk("seed0_random", {12'd0, random}, 16'h3);
    frames_no_tick(7);
    frame(1'b1, 1'b1, 16'h1234);
    chk("seed_tick_random_held", {12'd0, random}, 16'h3);
    frames_no_tick(7);
    speed_level = 2'd3;
    frame(1'b1);
    chk("after_seed_random", {12'd0, random}, 16'h9);

    // Wrap tick_count, then restart the frame count via enable.
    while (m_tcount != 8'd0) begin
      frame(1'b0);
      frame(1'b1);
    end
    chk("tick_count_wrap", {8'd0, tick_count}, 16'd0);
    frame(1'b0);
    enable = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("state_idle", {14'd0, state}, 16'd0);
    enable = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    frame(1'b0);
    frame(1'b1);

    // Reset on the timer_done cycle.
    frame(1'b0);
    @(negedge CLK);
    startOfFrame = 1'b1;
    @(posedge CLK);
    #1;
    startOfFrame = 1'b0;
    chk("pre_reset_timer_done", {15'd0, timer_done}, 16'd1);
    RESET = 1'b1;
    #1;
    chk("reset_mid_timer_done", {15'd0, timer_done}, 16'd0);
    chk("reset_mid_random", {12'd0, random}, 16'd0);
    chk("reset_mid_tick_count", {8'd0, tick_count}, 16'd0);
    chk("reset_mid_state", {14'd0, state}, 16'd0);
    @(negedge CLK);
    speed_level = 2'd0;
    m_lfsr = 16'hACE1;
    m_random = 4'd0;
    m_tcount = 8'd0;
    RESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    frames_no_tick(7);
    frame(1'b1);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
